// File: rtl/vexriscv_mem_arbiter_if.sv
// Bus bundle between the VexRiscv iBus/dBus masters, the arbiter and a
// single-port synchronous RAM. The arbiter uses the slave modport; the
// environment (CPU side plus RAM) uses the master modport.
interface vexriscv_mem_arbiter_if #(
    parameter int unsigned MEM_WORDS = 4096
);
    localparam int unsigned MEM_ADDR_W = $clog2(MEM_WORDS);

    // Instruction bus
    logic                  iBus_cmd_valid;
    logic                  iBus_cmd_ready;
    logic [31:0]           iBus_cmd_payload_pc;
    logic                  iBus_rsp_valid;
    logic                  iBus_rsp_payload_error;
    logic [31:0]           iBus_rsp_payload_inst;

    // Data bus
    logic                  dBus_cmd_valid;
    logic                  dBus_cmd_ready;
    logic                  dBus_cmd_payload_wr;
    logic [31:0]           dBus_cmd_payload_address;
    logic [31:0]           dBus_cmd_payload_data;
    logic [1:0]            dBus_cmd_payload_size;
    logic                  dBus_rsp_ready;
    logic                  dBus_rsp_error;
    logic [31:0]           dBus_rsp_data;

    // Shared RAM port
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  iBus_cmd_valid, iBus_cmd_payload_pc,
        output iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        input  dBus_cmd_payload_data, dBus_cmd_payload_size,
        output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output iBus_cmd_valid, iBus_cmd_payload_pc,
        input  iBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst,
        output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
        output dBus_cmd_payload_data, dBus_cmd_payload_size,
        input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vexriscv_mem_arbiter.sv
// Two-master arbiter in front of one single-port RAM with 1-cycle read latency.
// dBus has priority, but iBus is forced through after DBUS_STREAK_MAX
// consecutive dBus grants while it waits. Out-of-range reads answer with an
// error; out-of-range writes vanish.
module vexriscv_mem_arbiter #(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter int unsigned DBUS_STREAK_MAX = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    vexriscv_mem_arbiter_if.slave bus
);
    localparam int unsigned MEM_ADDR_W = $clog2(MEM_WORDS);
    localparam int unsigned STREAK_W   = $clog2(DBUS_STREAK_MAX + 1);

    typedef enum logic [1:0] {
        OwnNone,
        OwnIbus,
        OwnDbus
    } owner_e;

    logic                enabledQ;    // low for the first cycle after reset release
    owner_e              ownerQ, ownerD;
    logic                errorQ, errorD;
    logic [STREAK_W-1:0] streakQ, streakD;

    logic        grantI, grantD;
    logic        accept;
    logic        cmdWrite;
    logic        inRange;
    logic [31:0] cmdAddr;

    // Grant decision and the selected command fields
    always_comb begin
        grantD   = enabledQ && bus.dBus_cmd_valid &&
                   !(bus.iBus_cmd_valid && (streakQ == STREAK_W'(DBUS_STREAK_MAX)));
        grantI   = enabledQ && bus.iBus_cmd_valid && !grantD;
        accept   = grantI || grantD;
        cmdAddr  = grantD ? bus.dBus_cmd_payload_address : bus.iBus_cmd_payload_pc;
        cmdWrite = grantD && bus.dBus_cmd_payload_wr;
        inRange  = (cmdAddr >> (MEM_ADDR_W + 2)) == 32'd0;
    end

    // Command handshake and RAM port drive
    always_comb begin
        bus.iBus_cmd_ready = grantI;
        bus.dBus_cmd_ready = grantD;
        bus.mem_en         = accept && inRange;
        bus.mem_addr       = cmdAddr[MEM_ADDR_W+1:2];
        bus.mem_wdata      = bus.dBus_cmd_payload_data;
        bus.mem_we         = 4'b0000;
        if (bus.mem_en && cmdWrite) begin
            unique case (bus.dBus_cmd_payload_size)
                2'd0:    bus.mem_we = 4'b0001 << cmdAddr[1:0];
                2'd1:    bus.mem_we = 4'b0011 << {cmdAddr[1], 1'b0};
                default: bus.mem_we = 4'b1111;
            endcase
        end
    end

    // Next streak count and response bookkeeping
    always_comb begin
        streakD = streakQ;
        ownerD  = OwnNone;
        errorD  = 1'b0;
        if (!bus.iBus_cmd_valid || grantI) begin
            streakD = '0;
        end else if (grantD && (streakQ != STREAK_W'(DBUS_STREAK_MAX))) begin
            streakD = streakQ + 1'b1;
        end
        // Writes never answer, so only reads claim the response slot
        if (accept && !cmdWrite) begin
            ownerD = grantI ? OwnIbus : OwnDbus;
            errorD = !inRange;
        end
    end

    // State registers; reset drops any pending response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enabledQ <= 1'b0;
            ownerQ   <= OwnNone;
            errorQ   <= 1'b0;
            streakQ  <= '0;
        end else begin
            enabledQ <= 1'b1;
            ownerQ   <= ownerD;
            errorQ   <= errorD;
            streakQ  <= streakD;
        end
    end

    // Response outputs, zeroed whenever not valid or errored
    always_comb begin
        bus.iBus_rsp_valid         = (ownerQ == OwnIbus);
        bus.iBus_rsp_payload_error = bus.iBus_rsp_valid && errorQ;
        bus.iBus_rsp_payload_inst  = (bus.iBus_rsp_valid && !errorQ) ? bus.mem_rdata : 32'd0;
        bus.dBus_rsp_ready         = (ownerQ == OwnDbus);
        bus.dBus_rsp_error         = bus.dBus_rsp_ready && errorQ;
        bus.dBus_rsp_data          = (bus.dBus_rsp_ready && !errorQ) ? bus.mem_rdata : 32'd0;
    end
endmodule

// File: tb/tb_vexriscv_mem_arbiter.sv
// Bench for vexriscv_mem_arbiter: table of per-cycle commands with expected
// grants/RAM strobes, a reference RAM image, and a queue of expected responses.
module tb_vexriscv_mem_arbiter;
    localparam int unsigned MEM_WORDS = 4096;

    logic clk;
    logic reset_n;

    vexriscv_mem_arbiter_if #(.MEM_WORDS(MEM_WORDS)) bus ();

    vexriscv_mem_arbiter #(
        .MEM_WORDS      (MEM_WORDS),
        .DBUS_STREAK_MAX(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int unsigned i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'h3C00_0000 ^ (i * 32'h0001_0101);
    endfunction

    // RAM behind the arbiter: byte-write, registered read
    logic [31:0] ram [MEM_WORDS];
    bit          ramLoaded;
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= pattern(i);
            ramLoaded <= 1'b1;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        iV;
        logic [31:0] pc;
        logic        dV;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        expI;
        logic        expD;
        logic        expEn;
        logic [3:0]  expWe;
        logic [11:0] expAddr;
    } vec_t;

    typedef struct packed {
        logic        isI;
        logic        isD;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] refMem [MEM_WORDS];
    rsp_t        expQ[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic iV, input logic [31:0] pc, input logic dV,
                                input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic expI, input logic expD,
                                input logic expEn, input logic [3:0] expWe,
                                input logic [11:0] expAddr);
        vec_t v;
        v.iV = iV; v.pc = pc; v.dV = dV; v.wr = wr; v.addr = addr; v.data = data;
        v.size = size; v.expI = expI; v.expD = expD; v.expEn = expEn; v.expWe = expWe;
        v.expAddr = expAddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkRsp(input string tag);
        rsp_t e;
        e = '0;
        if (expQ.size() > 0) e = expQ.pop_front();
        check({tag, " iRspValid"}, 32'(bus.iBus_rsp_valid), 32'(e.isI));
        check({tag, " iRspError"}, 32'(bus.iBus_rsp_payload_error), 32'(e.isI && e.err));
        check({tag, " iRspInst"}, bus.iBus_rsp_payload_inst, e.isI ? e.data : 32'd0);
        check({tag, " dRspReady"}, 32'(bus.dBus_rsp_ready), 32'(e.isD));
        check({tag, " dRspError"}, 32'(bus.dBus_rsp_error), 32'(e.isD && e.err));
        check({tag, " dRspData"}, bus.dBus_rsp_data, e.isD ? e.data : 32'd0);
    endtask

    function automatic rsp_t readRsp(input logic isI, input logic [31:0] a);
        rsp_t r;
        r.isI  = isI;
        r.isD  = !isI;
        r.err  = (a >= 32'h4000);
        r.data = r.err ? 32'd0 : refMem[a[13:2]];
        return r;
    endfunction

    task automatic driveIdle();
        bus.iBus_cmd_valid           = 1'b0;
        bus.iBus_cmd_payload_pc      = 32'd0;
        bus.dBus_cmd_valid           = 1'b0;
        bus.dBus_cmd_payload_wr      = 1'b0;
        bus.dBus_cmd_payload_address = 32'd0;
        bus.dBus_cmd_payload_data    = 32'd0;
        bus.dBus_cmd_payload_size    = 2'd0;
    endtask

    // Called just after a rising edge; returns just after the next one
    task automatic applyVec(input vec_t v, input int idx);
        string tag;
        rsp_t  none;
        none = '0;
        tag  = $sformatf("v%0d", idx);
        bus.iBus_cmd_valid           = v.iV;
        bus.iBus_cmd_payload_pc      = v.pc;
        bus.dBus_cmd_valid           = v.dV;
        bus.dBus_cmd_payload_wr      = v.wr;
        bus.dBus_cmd_payload_address = v.addr;
        bus.dBus_cmd_payload_data    = v.data;
        bus.dBus_cmd_payload_size    = v.size;
        @(negedge clk);
        checkRsp(tag);
        check({tag, " iReady"}, 32'(bus.iBus_cmd_ready), 32'(v.expI));
        check({tag, " dReady"}, 32'(bus.dBus_cmd_ready), 32'(v.expD));
        check({tag, " memEn"}, 32'(bus.mem_en), 32'(v.expEn));
        check({tag, " memWe"}, 32'(bus.mem_we), 32'(v.expWe));
        if (v.expEn) check({tag, " memAddr"}, 32'(bus.mem_addr), 32'(v.expAddr));
        if (v.expEn && v.wr) check({tag, " memWdata"}, bus.mem_wdata, v.data);
        if (v.expI) begin
            expQ.push_back(readRsp(1'b1, v.pc));
        end else if (v.expD && !v.wr) begin
            expQ.push_back(readRsp(1'b0, v.addr));
        end else begin
            if (v.expD && v.wr && v.addr < 32'h4000)
                for (int b = 0; b < 4; b++)
                    if (v.expWe[b]) refMem[v.addr[13:2]][8*b +: 8] = v.data[8*b +: 8];
            expQ.push_back(none);
        end
        @(posedge clk);
        #1;
    endtask

    // Checks outputs under reset, releases it, checks the no-grant first cycle
    task automatic releaseReset(input string tag);
        rsp_t none;
        none = '0;
        bus.iBus_cmd_valid           = 1'b1;
        bus.iBus_cmd_payload_pc      = 32'h10;
        bus.dBus_cmd_valid           = 1'b1;
        bus.dBus_cmd_payload_address = 32'h0;
        @(negedge clk);
        check({tag, " rst iReady"}, 32'(bus.iBus_cmd_ready), 32'd0);
        check({tag, " rst dReady"}, 32'(bus.dBus_cmd_ready), 32'd0);
        check({tag, " rst memEn"}, 32'(bus.mem_en), 32'd0);
        check({tag, " rst memWe"}, 32'(bus.mem_we), 32'd0);
        checkRsp({tag, " rst"});
        reset_n = 1'b1;
        #1;
        check({tag, " first iReady"}, 32'(bus.iBus_cmd_ready), 32'd0);
        check({tag, " first dReady"}, 32'(bus.dBus_cmd_ready), 32'd0);
        check({tag, " first memEn"}, 32'(bus.mem_en), 32'd0);
        expQ.push_back(none);
        @(posedge clk);
        #1;
        driveIdle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        driveIdle();
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = pattern(i);

        //          iV pc            dV wr addr          data          sz  I  D  En we       addr
        vecs.push_back(mk(1, 32'h10,   0, 0, 32'h0,    32'h0,        2, 1, 0, 1, 4'b0000, 12'h004));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h103,  32'hAAAAAAAA, 0, 0, 1, 1, 4'b1000, 12'h040));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h100,  32'h0,        2, 0, 1, 1, 4'b0000, 12'h040));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h202,  32'h12345678, 1, 0, 1, 1, 4'b1100, 12'h080));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h201,  32'hCAFEF00D, 1, 0, 1, 1, 4'b0011, 12'h080));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h300,  32'h0BADF00D, 2, 0, 1, 1, 4'b1111, 12'h0C0));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h305,  32'h11111111, 3, 0, 1, 1, 4'b1111, 12'h0C1));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h200,  32'h0,        2, 0, 1, 1, 4'b0000, 12'h080));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h4000, 32'h0,        2, 0, 1, 0, 4'b0000, 12'h000));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h4004, 32'h77777777, 2, 0, 1, 0, 4'b0000, 12'h000));
        vecs.push_back(mk(1, 32'h8000, 0, 0, 32'h0,    32'h0,        2, 1, 0, 0, 4'b0000, 12'h000));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h300,  32'h0,        2, 0, 1, 1, 4'b0000, 12'h0C0));
        vecs.push_back(mk(1, 32'h304,  0, 0, 32'h0,    32'h0,        2, 1, 0, 1, 4'b0000, 12'h0C1));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h10,   32'h0,        2, 0, 1, 1, 4'b0000, 12'h004));
        vecs.push_back(mk(1, 32'h100,  0, 0, 32'h0,    32'h0,        2, 1, 0, 1, 4'b0000, 12'h040));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h302,  32'h55667788, 0, 0, 1, 1, 4'b0100, 12'h0C0));
        vecs.push_back(mk(0, 32'h0,    1, 0, 32'h300,  32'h0,        2, 0, 1, 1, 4'b0000, 12'h0C0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 4'b0000, 12'h000));
        vecs.push_back(mk(0, 32'h0,    1, 1, 32'h3FFF, 32'h9A9A9A9A, 0, 0, 1, 1, 4'b1000, 12'hFFF));
        vecs.push_back(mk(1, 32'h3FFC, 0, 0, 32'h0,    32'h0,        2, 1, 0, 1, 4'b0000, 12'hFFF));
        vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,    32'h0,        0, 0, 0, 0, 4'b0000, 12'h000));
        // Both masters busy: D,D,D,D,I repeating
        for (int j = 0; j < 10; j++) begin
            logic isI;
            isI = (j % 5 == 4);
            vecs.push_back(mk(1, 32'h40, 1, 0, 32'h800 + 32'(4 * j), 32'h0, 2, isI, !isI, 1,
                              4'b0000, isI ? 12'h010 : 12'(32'h200 + 32'(j))));
        end
        // iBus dropping valid for one cycle restarts the streak
        for (int j = 0; j < 9; j++) begin
            vecs.push_back(mk(j != 3, 32'h44, 1, 0, 32'h900 + 32'(4 * j), 32'h0, 2, j == 8,
                              j != 8, 1, 4'b0000, (j == 8) ? 12'h011 : 12'(32'h240 + 32'(j))));
        end
        vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 12'h000));

        repeat (2) @(posedge clk);
        releaseReset("init");

        k = 0;
        foreach (vecs[i]) begin
            applyVec(vecs[i], k);
            k++;
        end

        // Reset during a pending iBus response
        applyVec(mk(1, 32'h20, 0, 0, 32'h0, 32'h0, 2, 1, 0, 1, 4'b0000, 12'h008), k);
        k++;
        check("preReset iRspValid", 32'(bus.iBus_rsp_valid), 32'd1);
        reset_n = 1'b0;
        bus.iBus_cmd_valid = 1'b1;
        #1;
        check("inReset iRspValid", 32'(bus.iBus_rsp_valid), 32'd0);
        check("inReset iRspInst", bus.iBus_rsp_payload_inst, 32'd0);
        check("inReset iReady", 32'(bus.iBus_cmd_ready), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        releaseReset("rerun");
        applyVec(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 12'h000), k);
        k++;
        applyVec(mk(1, 32'h10, 0, 0, 32'h0, 32'h0, 2, 1, 0, 1, 4'b0000, 12'h004), k);
        k++;
        applyVec(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 4'b0000, 12'h000), k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
